// File: rtl/control_unit_pkg.sv
// Shared definitions for the multicycle control unit and ALU: ALU operation
// codes, FSM state enumeration, opcode constants and decoder mode selects.
package control_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_SRA = 4'h3,
    ALU_OR  = 4'h4,
    ALU_XOR = 4'h5,
    ALU_SLL = 4'h6,
    ALU_SRL = 4'h7,
    ALU_EQ  = 4'h8,
    ALU_NEQ = 4'h9,
    ALU_LTU = 4'hA,
    ALU_LT  = 4'hB,
    ALU_GEU = 4'hC,
    ALU_GE  = 4'hD
  } alu_ctrl_e;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_U, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_MEM, S_WB_ALU, S_BRANCH, S_JAL, S_JALR, S_TRAP
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] ALUOP_ADD = 2'd0;
  localparam logic [1:0] ALUOP_R   = 2'd1;
  localparam logic [1:0] ALUOP_I   = 2'd2;
  localparam logic [1:0] ALUOP_BR  = 2'd3;

endpackage

// File: rtl/control_unit_alu_decoder.sv
// funct3/funct7[5] to ALU operation mapping, selected by the FSM's decode mode.
module alu_decoder
  import control_unit_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_R, ALUOP_I: begin
        case (funct3)
          3'd0: alu_control = (alu_op == ALUOP_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'd1: alu_control = ALU_SLL;
          3'd2: alu_control = ALU_LT;
          3'd3: alu_control = ALU_LTU;
          3'd4: alu_control = ALU_XOR;
          3'd5: alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
          3'd6: alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      ALUOP_BR: begin
        case (funct3)
          3'd0: alu_control = ALU_EQ;
          3'd1: alu_control = ALU_NEQ;
          3'd4: alu_control = ALU_LT;
          3'd5: alu_control = ALU_GE;
          3'd6: alu_control = ALU_LTU;
          3'd7: alu_control = ALU_GEU;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle RISC-V control FSM. Define ILLEGAL_TRAP_EN to trap (sticky
// illegal) on unknown instructions; otherwise they retire as NOPs.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero_lsb,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [2:0]  imm_src,
  output logic [3:0]  alu_control,
  output logic        illegal
);

`ifdef ILLEGAL_TRAP_EN
  localparam state_e S_ILLEGAL = S_TRAP;
`else
  localparam state_e S_ILLEGAL = S_FETCH;
`endif

  state_e     state, next_state;
  logic [1:0] alu_op;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7_5     = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .alu_control (alu_control)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_FETCH;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    imm_src    = IMM_I;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = IMM_B;
        case (opcode)
          OP_R:              next_state = S_EXEC_R;
          OP_I:              next_state = S_EXEC_I;
          OP_LOAD, OP_STORE: next_state = S_MEM_ADDR;
          OP_BRANCH:         next_state = (funct3[2:1] == 2'b01) ? S_ILLEGAL : S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_LUI, OP_AUIPC:  next_state = S_EXEC_U;
          default:           next_state = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a  = 2'b10;
        alu_op     = ALUOP_R;
        next_state = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = ALUOP_I;
        next_state = S_WB_ALU;
      end
      S_EXEC_U: begin
        alu_src_a  = (opcode == OP_LUI) ? 2'b11 : 2'b01;
        alu_src_b  = 2'b01;
        imm_src    = IMM_U;
        next_state = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        imm_src    = (opcode == OP_STORE) ? IMM_S : IMM_I;
        next_state = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) next_state = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        next_state = S_FETCH;
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = ALUOP_BR;
        pc_write   = alu_zero_lsb;
        next_state = S_FETCH;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        next_state = S_JAL;
      end
      S_JAL: begin
        // PC takes the target latched in ALUOut while old_pc+4 is formed for rd
        pc_write   = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        next_state = S_WB_ALU;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        illegal    = 1'b1;
        next_state = S_TRAP;
`else
        next_state = S_FETCH;
`endif
      end
      default: next_state = S_FETCH;
    endcase

    // Outputs are forced idle while reset is held, independent of the clock
    if (!resetn) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      imm_src    = IMM_I;
      alu_op     = ALUOP_ADD;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; expected output words are
// hand-built per FSM state. Honours ILLEGAL_TRAP_EN like the design.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] instr = '0;
  logic        mem_ready = 1'b0;
  logic        alu_zero_lsb = 1'b0;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  imm_src;
  logic [3:0]  alu_control;
  logic        illegal;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .alu_zero_lsb (alu_zero_lsb),
    .mem_req      (mem_req),
    .mem_write    (mem_write),
    .adr_src      (adr_src),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .result_src   (result_src),
    .imm_src      (imm_src),
    .alu_control  (alu_control),
    .illegal      (illegal)
  );

  // {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,a,b,res,imm,alu,illegal}
  logic [19:0] obs;
  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, imm_src, alu_control, illegal};

  function automatic logic [19:0] e(input logic [5:0] strb, input logic [1:0] a,
                                    input logic [1:0] b, input logic [1:0] rs,
                                    input logic [2:0] imm, input logic [3:0] aluc,
                                    input logic ill);
    return {strb, a, b, rs, imm, aluc, ill};
  endfunction

  localparam logic [19:0] E_FETCH   = {6'b100000, 2'b00, 2'b10, 2'b10, 3'd0, 4'h0, 1'b0};
  localparam logic [19:0] E_FETCH_R = {6'b100110, 2'b00, 2'b10, 2'b10, 3'd0, 4'h0, 1'b0};
  localparam logic [19:0] E_DECODE  = {6'b000000, 2'b01, 2'b01, 2'b00, 3'd2, 4'h0, 1'b0};
  localparam logic [19:0] E_WB_ALU  = {6'b000001, 2'b00, 2'b00, 2'b00, 3'd0, 4'h0, 1'b0};
  localparam logic [19:0] E_WB_MEM  = {6'b000001, 2'b00, 2'b00, 2'b01, 3'd0, 4'h0, 1'b0};
  localparam logic [19:0] E_JAL     = {6'b000010, 2'b01, 2'b10, 2'b00, 3'd0, 4'h0, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check outputs mid-cycle, then advance to just after the next rising edge
  task automatic step(input string tag, input logic [19:0] exp);
    @(negedge clk);
    #1;
    check(tag, {12'h0, obs}, {12'h0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input int unsigned waits);
    mem_ready = 1'b0;
    for (int unsigned i = 0; i < waits; i++) step({tag, "_fetch_wait"}, E_FETCH);
    mem_ready = 1'b1;
    step({tag, "_fetch_rdy"}, E_FETCH_R);
    mem_ready = 1'b0;
    step({tag, "_decode"}, E_DECODE);
  endtask

  task automatic alu_instr(input string tag, input logic [31:0] ins, input logic is_r,
                           input logic [3:0] aluc);
    instr = ins;
    fetch(tag, 0);
    step({tag, "_exec"}, e(6'b0, 2'b10, is_r ? 2'b00 : 2'b01, 2'b00, 3'd0, aluc, 1'b0));
    step({tag, "_wb"}, E_WB_ALU);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #3;
    check("reset_outputs", {12'h0, obs}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check("reset_idle", {12'h0, obs}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // add x3,x1,x2 with memory ready on the 3rd fetch cycle
    instr = 32'h002081B3;
    fetch("add", 2);
    step("add_exec", e(6'b0, 2'b10, 2'b00, 2'b00, 3'd0, 4'h0, 1'b0));
    step("add_wb", E_WB_ALU);

    alu_instr("sub",  32'h402081B3, 1'b1, 4'h1);
    alu_instr("srai", 32'h40315093, 1'b0, 4'h3);
    alu_instr("sltu", 32'h0020B1B3, 1'b1, 4'hA);
    alu_instr("andi", 32'h00517093, 1'b0, 4'h2);
    alu_instr("addi_neg", 32'hC0010093, 1'b0, 4'h0);

    instr = 32'h00208463;
    fetch("beq", 0);
    alu_zero_lsb = 1'b1;
    step("beq_branch", e(6'b000010, 2'b10, 2'b00, 2'b00, 3'd0, 4'h8, 1'b0));
    alu_zero_lsb = 1'b0;

    instr = 32'h00209463;
    fetch("bne", 0);
    step("bne_branch", e(6'b000000, 2'b10, 2'b00, 2'b00, 3'd0, 4'h9, 1'b0));

    // lw: stray mem_ready in MEM_ADDR must be ignored, then 2 wait cycles
    instr = 32'h0000A083;
    fetch("lw", 0);
    mem_ready = 1'b1;
    step("lw_addr", e(6'b0, 2'b10, 2'b01, 2'b00, 3'd0, 4'h0, 1'b0));
    mem_ready = 1'b0;
    step("lw_rd_wait0", e(6'b101000, 2'b00, 2'b00, 2'b00, 3'd0, 4'h0, 1'b0));
    step("lw_rd_wait1", e(6'b101000, 2'b00, 2'b00, 2'b00, 3'd0, 4'h0, 1'b0));
    mem_ready = 1'b1;
    step("lw_rd_done", e(6'b101000, 2'b00, 2'b00, 2'b00, 3'd0, 4'h0, 1'b0));
    mem_ready = 1'b0;
    step("lw_wb", E_WB_MEM);

    instr = 32'h008000EF;
    fetch("jal", 0);
    step("jal_jal", E_JAL);
    step("jal_wb", E_WB_ALU);

    instr = 32'h000080E7;
    fetch("jalr", 0);
    step("jalr_addr", e(6'b0, 2'b10, 2'b01, 2'b00, 3'd0, 4'h0, 1'b0));
    step("jalr_jal", E_JAL);
    step("jalr_wb", E_WB_ALU);

    instr = 32'h000010B7;
    fetch("lui", 0);
    step("lui_exec", e(6'b0, 2'b11, 2'b01, 2'b00, 3'd3, 4'h0, 1'b0));
    step("lui_wb", E_WB_ALU);

    instr = 32'h00001097;
    fetch("auipc", 0);
    step("auipc_exec", e(6'b0, 2'b01, 2'b01, 2'b00, 3'd3, 4'h0, 1'b0));
    step("auipc_wb", E_WB_ALU);

    // sw interrupted by reset while waiting in MEM_WR
    instr = 32'h0020A023;
    fetch("sw", 0);
    step("sw_addr", e(6'b0, 2'b10, 2'b01, 2'b00, 3'd1, 4'h0, 1'b0));
    @(negedge clk);
    #1;
    check("sw_wr", {12'h0, obs}, {12'h0, e(6'b111000, 2'b00, 2'b00, 2'b00, 3'd0, 4'h0, 1'b0)});
    resetn = 1'b0;
    #1;
    check("sw_reset_async", {12'h0, obs}, 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    check("sw_restart_fetch", {12'h0, obs}, {12'h0, E_FETCH});
    @(posedge clk);
    #1;
    step("after_reset_fetch", E_FETCH);

    // illegal opcode 0000000
    instr = 32'h00000000;
    fetch("ill", 0);
    mem_ready = 1'b1;
`ifdef ILLEGAL_TRAP_EN
    step("ill_trap0", e(6'b0, 2'b00, 2'b00, 2'b00, 3'd0, 4'h0, 1'b1));
    step("ill_trap1", e(6'b0, 2'b00, 2'b00, 2'b00, 3'd0, 4'h0, 1'b1));
    step("ill_trap2", e(6'b0, 2'b00, 2'b00, 2'b00, 3'd0, 4'h0, 1'b1));
`else
    step("ill_nop_fetch", E_FETCH_R);
    mem_ready = 1'b0;
    step("ill_nop_decode", E_DECODE);
`endif
    mem_ready = 1'b0;
    do_reset();
    step("final_fetch", E_FETCH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports: clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have ports: resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports: instr, input, 32, instruction register contents (opcode, funct3, funct7[5] are decoded).
REQ-004 SHALL have ports: mem_ready, input, 1, memory handshake completion.
REQ-005 SHALL have ports: alu_zero_lsb, input, 1, bit 0 of the ALU result (comparison outcome).
REQ-006 SHALL have outputs: mem_req 1, mem_write 1, adr_src 1 (0=PC, 1=ALUOut), ir_write 1, pc_write 1, reg_write 1.
REQ-007 SHALL have outputs: alu_src_a 2 (00 PC, 01 old_pc, 10 rs1, 11 zero), alu_src_b 2 (00 rs2, 01 imm, 10 const 4), result_src 2 (00 ALUOut, 01 mem data, 10 ALU result), imm_src 3 (0 I, 1 S, 2 B, 3 U, 4 J), alu_control 4, illegal 1.

Function
REQ-008 SHALL drive alu_control with the ALU encoding: ADD 0, SUB 1, AND 2, SRA 3, OR 4, XOR 5, SLL 6, SRL 7, EQ 8, NEQ 9, LTU A, LT B, GEU C, GE D.
REQ-009 SHALL implement the states FETCH, DECODE, EXEC_R, EXEC_I, EXEC_U, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, WB_ALU, BRANCH, JAL, JALR, TRAP.
REQ-010 SHALL drive all control outputs combinationally from the current state and instr, with zero/ADD defaults in every state.
REQ-011 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, ADD, result_src=10; ir_write and pc_write SHALL pulse only in the cycle mem_ready=1, which moves the FSM to DECODE; otherwise the FSM holds FETCH.
REQ-012 DECODE SHALL compute old_pc+imm (alu_src_a=01, alu_src_b=01, ADD, imm_src=B) and branch on opcode: 0110011->EXEC_R, 0010011->EXEC_I, 0000011/0100011->MEM_ADDR, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111/0010111->EXEC_U, else illegal path.
REQ-013 funct3 decode SHALL map 0->ADD (SUB when R-type and funct7[5]), 1->SLL, 2->LT, 3->LTU, 4->XOR, 5->SRL (SRA when funct7[5]), 6->OR, 7->AND; I-type funct3=0 SHALL always yield ADD.
REQ-014 BRANCH SHALL set alu_src_a=10, alu_src_b=00, funct3 0/1/4/5/6/7 -> EQ/NEQ/LT/GE/LTU/GEU, result_src=00, pc_write=alu_zero_lsb, then FETCH; funct3 2/3 are illegal.
REQ-015 MEM_ADDR SHALL compute rs1+imm (imm_src I for loads, S for stores) then go to MEM_RD or MEM_WR.
REQ-016 MEM_RD/MEM_WR SHALL assert mem_req, adr_src=1 (mem_write=1 in MEM_WR) and hold until mem_ready; MEM_RD->WB_MEM, MEM_WR->FETCH.
REQ-017 WB_MEM SHALL assert reg_write with result_src=01; WB_ALU SHALL assert reg_write with result_src=00; both go to FETCH.
REQ-018 JALR SHALL compute rs1+imm (I) into ALUOut then go to JAL; JAL SHALL assert pc_write, result_src=00, compute old_pc+4, then WB_ALU.
REQ-019 EXEC_U SHALL use imm_src=U, alu_src_b=01, alu_src_a=11 (LUI) or 01 (AUIPC), ADD, then WB_ALU.
REQ-020 mem_ready outside FETCH/MEM_RD/MEM_WR SHALL be ignored.

Reset
REQ-021 resetn low SHALL force state FETCH immediately and all outputs to 0 (alu_control=ADD, illegal=0) regardless of clk, including mid-handshake.
REQ-022 First FETCH SHALL begin on the first rising edge after resetn deasserts.

Configuration
REQ-023 With ILLEGAL_TRAP_EN defined, an illegal instruction SHALL enter TRAP, set illegal=1 sticky, and hold TRAP with all strobes 0 until reset.
REQ-024 Without ILLEGAL_TRAP_EN, an illegal instruction SHALL return to FETCH as a NOP, illegal SHALL be tied 0, and TRAP SHALL be unreachable.

Structure
REQ-025 The ALU encoding constants, the state enumeration and the opcode constants SHALL live in a shared package used by control_unit and the ALU.
REQ-026 funct3/funct7 to alu_control mapping SHALL be a sub-module alu_decoder; the FSM SHALL remain in control_unit.

Verification
REQ-027 add x3,x1,x2 with mem_ready on 3rd FETCH cycle -> FETCH held 3 cycles, then DECODE, EXEC_R (alu_control=0), WB_ALU reg_write=1, FETCH.
REQ-028 sub (funct7[5]=1) -> alu_control=1; srai -> 3; sltu -> A; andi -> 2.
REQ-029 beq with alu_zero_lsb=1 -> BRANCH alu_control=8, pc_write=1; bne with alu_zero_lsb=0 -> alu_control=9, pc_write=0.
REQ-030 lw with mem_ready delayed 2 cycles -> MEM_RD holds mem_req=1, adr_src=1 for 3 cycles, then WB_MEM result_src=01 reg_write=1.
REQ-031 opcode 0000000 -> with ILLEGAL_TRAP_EN: TRAP, illegal=1 until resetn; without: back to FETCH, illegal=0.
REQ-032 resetn pulled low during MEM_WR -> mem_write/mem_req drop to 0 without a clock edge; FSM restarts in FETCH.
